// File: rtl/digit_serial_subtract.sv
// rtl/digit_serial_subtract.sv - digit-serial N-bit subtractor, W bits per cycle, valid/ready in and out
// One W-bit borrow slice walks the operands LSB-first; the difference fills from the MSB end.
module digit_serial_subtract #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bo,
    output logic         ov
);

    localparam int D  = N / W;
    localparam int CW = $clog2(D) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   diff_q, diff_d;
    logic           brw_q, brw_d;
    logic           bo_q, bo_d;
    logic           ov_q, ov_d;
    logic [CW-1:0]  count_q, count_d;

    logic [W:0]     slice;
    logic [W-1:0]   dig;
    logic [N-1:0]   diff_shift;

    // Borrow-chain slice: the carried borrow links consecutive digits like a full-width subtract.
    assign slice = {1'b0, a_q[W-1:0]} - {1'b0, b_q[W-1:0]} - {{W{1'b0}}, brw_q};
    assign dig   = slice[W-1:0];

    generate
        if (W == N) begin : g_single_digit
            assign diff_shift = dig;
        end else begin : g_multi_digit
            assign diff_shift = {dig, diff_q[N-1:W]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        bo_d    = bo_q;
        ov_d    = ov_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bi;
                    count_d = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                diff_d  = diff_shift;
                brw_d   = slice[W];
                a_d     = a_q >> W;
                b_d     = b_q >> W;
                count_d = count_q + 1'b1;
                // On the last digit the low W bits of a_q/b_q hold the original operand MSBs.
                if (count_q == CW'(D - 1)) begin
                    bo_d    = slice[W];
                    ov_d    = (a_q[W-1] ^ b_q[W-1]) & (a_q[W-1] ^ dig[W-1]);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            bo_q    <= 1'b0;
            ov_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            bo_q    <= bo_d;
            ov_q    <= ov_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign d         = diff_q;
    assign bo        = bo_q;
    assign ov        = ov_q;

endmodule

// File: tb/tb_digit_serial_subtract.sv
// tb/tb_digit_serial_subtract.sv - scoreboard bench for digit_serial_subtract (N=32, W=8)
module tb_digit_serial_subtract;

    localparam int N = 32;
    localparam int W = 8;
    localparam int D = N / W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          bi = 1'b0;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  d;
    logic          bo;
    logic          ov;

    typedef struct packed {
        logic [N-1:0] d;
        logic         bo;
        logic         ov;
    } res_t;

    res_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   rdy_rand = 1'b0;
    logic rdy_force = 1'b0;

    digit_serial_subtract #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bo        (bo),
        .ov        (ov)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic res_t mk(input logic [N-1:0] dv, input logic bov, input logic ovv);
        res_t r;
        r.d  = dv;
        r.bo = bov;
        r.ov = ovv;
        return r;
    endfunction

    function automatic res_t model(input logic [N-1:0] av, input logic [N-1:0] bv, input logic biv);
        logic [N:0] t;
        res_t       r;
        t    = {1'b0, av} - {1'b0, bv} - {{N{1'b0}}, biv};
        r.d  = t[N-1:0];
        r.bo = t[N];
        r.ov = (av[N-1] ^ bv[N-1]) & (av[N-1] ^ t[N-1]);
        return r;
    endfunction

    // Issue one operand set; push the expected result only when the handshake completes.
    task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input logic biv,
                        input res_t e, input bit push);
        bit ok;
        ok       = 1'b0;
        a        = av;
        b        = bv;
        bi       = biv;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("accept", 64'(ok), 64'd1);
        if (ok) begin
            @(posedge clk);
            if (push) sb.push_back(e);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                chk("result expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("d", 64'(d), 64'(e.d));
                    chk("bo", 64'(bo), 64'(e.bo));
                    chk("ov", 64'(ov), 64'(e.ov));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] ra, rb;
        logic         rbi;
        bit           seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst d", 64'(d), 64'd0);
        chk("rst bo", 64'(bo), 64'd0);
        chk("rst ov", 64'(ov), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: accepted at edge k, out_valid first high after edge k+D.
        send(32'd5, 32'd3, 1'b0, mk(32'h0000_0002, 1'b0, 1'b0), 1'b1);
        for (int i = 1; i <= D; i++) begin
            @(posedge clk);
            #1;
            chk("latency out_valid", 64'(out_valid), 64'(i == D));
        end
        rdy_force = 1'b1;
        drain();

        send(32'h0000_0000, 32'h0000_0001, 1'b0, mk(32'hFFFF_FFFF, 1'b1, 1'b0), 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, mk(32'h7FFF_FFFF, 1'b0, 1'b1), 1'b1);
        send(32'h0001_0000, 32'h0000_0001, 1'b1, mk(32'h0000_FFFE, 1'b0, 1'b0), 1'b1);
        send(32'h0000_0000, 32'h0000_0000, 1'b1, mk(32'hFFFF_FFFF, 1'b1, 1'b0), 1'b1);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, mk(32'h8000_0000, 1'b1, 1'b1), 1'b1);
        drain();

        // Back-pressure: result held in DONE, in_valid pulses ignored.
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, mk(32'h0123_4567, 1'b0, 1'b0), 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("bp reach done", 64'(seen), 64'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            #1;
            chk("bp out_valid", 64'(out_valid), 64'd1);
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp d", 64'(d), 64'h0123_4567);
            chk("bp bo_ov", 64'({bo, ov}), 64'd0);
        end
        in_valid  = 1'b0;
        rdy_force = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release in_ready", 64'(in_ready), 64'd1);
        drain();

        // Reset on the second BUSY edge aborts the op.
        send(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, mk('0, 1'b0, 1'b0), 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort d", 64'(d), 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd1);
        send(32'd100, 32'd58, 1'b0, mk(32'd42, 1'b0, 1'b0), 1'b1);
        drain();

        rdy_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rbi = 1'($urandom_range(0, 1));
            if (n % 7 == 0) rb = ra;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(ra, rb, rbi, model(ra, rb, rbi), 1'b1);
        end
        drain();
        rdy_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
